bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Four-cache round-robin bus arbiter with a one-cycle GRANT, a watchdog-guarded WAIT,
// and a dead RELEASE cycle between owners. Every output comes straight from a register.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       RdMs,
    input  logic [3:0]       WrMs,
    input  logic [3:0]       WrBk,
    input  logic [3:0][31:0] address,
    input  logic [3:0][31:0] value,
    input  logic             bus_done,
    output logic [3:0]       grant,
    output logic [1:0]       proc_ID_out,
    output logic             bus_valid,
    output logic             bus_RdMs,
    output logic             bus_WrMs,
    output logic             bus_WrBk,
    output logic [31:0]      address_out,
    output logic [31:0]      value_out,
    output logic             timeout_err
);

    localparam int CW = (TIMEOUT <= 255) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RELEASE} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_rd, r_wr, r_wb;
    logic [1:0]    r_ptr, w_ptr_next;
    logic [1:0]    r_owner, w_owner_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_grant, w_grant_next;
    logic [1:0]    r_id, w_id_next;
    logic          r_valid, w_valid_next;
    logic          r_cmd_rd, w_cmd_rd_next;
    logic          r_cmd_wr, w_cmd_wr_next;
    logic          r_cmd_wb, w_cmd_wb_next;
    logic [31:0]   r_addr, w_addr_next;
    logic [31:0]   r_val, w_val_next;
    logic          r_terr, w_terr_next;

    logic [3:0]    w_req;
    logic [3:0]    w_rot_req;
    logic [1:0]    w_rot_idx [4];
    logic [1:0]    w_off;
    logic [1:0]    w_winner;

    assign w_req = r_rd | r_wr | r_wb;

    // Rotate the request vector so that position 0 is the current round-robin pointer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot_idx[gi] = r_ptr + 2'(gi);
            assign w_rot_req[gi] = w_req[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot_req[k]) w_off = 2'(k);
        end
    end

    assign w_winner = r_ptr + w_off;

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_owner_next  = r_owner;
        w_cnt_next    = r_cnt;
        w_grant_next  = r_grant;
        w_id_next     = r_id;
        w_valid_next  = r_valid;
        w_cmd_rd_next = r_cmd_rd;
        w_cmd_wr_next = r_cmd_wr;
        w_cmd_wb_next = r_cmd_wb;
        w_addr_next   = r_addr;
        w_val_next    = r_val;
        w_terr_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_state_next  = S_GRANT;
                    w_owner_next  = w_winner;
                    w_id_next     = w_winner;
                    w_grant_next  = 4'b0001 << w_winner;
                    w_valid_next  = 1'b1;
                    w_cmd_wb_next = r_wb[w_winner];
                    w_cmd_wr_next = !r_wb[w_winner] && r_wr[w_winner];
                    w_cmd_rd_next = !r_wb[w_winner] && !r_wr[w_winner] && r_rd[w_winner];
                    w_addr_next   = address[w_winner];
                    w_val_next    = r_wb[w_winner] ? value[w_winner] : 32'd0;
                    w_cnt_next    = '0;
                end
            end
            S_GRANT: begin
                w_state_next = S_WAIT;
                w_cnt_next   = '0;
            end
            S_WAIT: begin
                // Completion beats owner-drop, which beats the watchdog.
                if (bus_done || !w_req[r_owner] || (TIMEOUT != 0 && r_cnt == TMAX)) begin
                    w_state_next  = S_RELEASE;
                    w_ptr_next    = r_owner + 2'd1;
                    w_grant_next  = 4'b0000;
                    w_valid_next  = 1'b0;
                    w_cmd_rd_next = 1'b0;
                    w_cmd_wr_next = 1'b0;
                    w_cmd_wb_next = 1'b0;
                    w_terr_next   = !bus_done && w_req[r_owner];
                end else if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd     <= '0;
            r_wr     <= '0;
            r_wb     <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_cmd_rd <= 1'b0;
            r_cmd_wr <= 1'b0;
            r_cmd_wb <= 1'b0;
            r_addr   <= '0;
            r_val    <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd     <= RdMs;
            r_wr     <= WrMs;
            r_wb     <= WrBk;
            r_ptr    <= w_ptr_next;
            r_owner  <= w_owner_next;
            r_cnt    <= w_cnt_next;
            r_grant  <= w_grant_next;
            r_id     <= w_id_next;
            r_valid  <= w_valid_next;
            r_cmd_rd <= w_cmd_rd_next;
            r_cmd_wr <= w_cmd_wr_next;
            r_cmd_wb <= w_cmd_wb_next;
            r_addr   <= w_addr_next;
            r_val    <= w_val_next;
            r_terr   <= w_terr_next;
        end
    end

    assign grant       = r_grant;
    assign proc_ID_out = r_id;
    assign bus_valid   = r_valid;
    assign bus_RdMs    = r_cmd_rd;
    assign bus_WrMs    = r_cmd_wr;
    assign bus_WrBk    = r_cmd_wb;
    assign address_out = r_addr;
    assign value_out   = r_val;
    assign timeout_err = r_terr;

endmodule
